// File: rtl/updn_cnt_arb_if.sv
// Command bus between two clients and the shared up/down counter sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: req is level-held by the client until its gnt pulse.
interface updn_cnt_arb_if #(
    parameter int WIDTH = 3
);
    logic             req0;
    logic             req1;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] arg0;
    logic [WIDTH-1:0] arg1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] count;

    // Client side: issues commands, observes grant/completion and the count.
    modport master (
        output req0, req1, op0, op1, arg0, arg1,
        input  gnt0, gnt1, busy, done, done_id, count
    );

    // Counter side: accepts commands, owns the count register.
    modport slave (
        input  req0, req1, op0, op1, arg0, arg1,
        output gnt0, gnt1, busy, done, done_id, count
    );
endinterface

// File: rtl/updn_cnt_arb.sv
// Round-robin arbiter/sequencer for a shared WIDTH-bit up/down counter.
// Latency: gnt 1 cycle after request sample; done after max(steps,1) more cycles.
// Backpressure: requests wait (req held) while busy; re-arbitrated on return to IDLE.
module updn_cnt_arb #(
    parameter int WIDTH = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    updn_cnt_arb_if.slave bus
);
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] remaining;   // step count for UP/DOWN, load value for LOAD
    logic             cmd_id;
    logic             last_id;
    logic             take;
    logic             pick;
    logic             finish;

    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic [WIDTH-1:0] count_q;

    // Next-state, arbitration choice and completion decode.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take      = 1'b1;
                    // On a tie the client not granted last wins.
                    pick      = (bus.req0 && bus.req1) ? ~last_id : bus.req1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                // Steps finish on the edge where remaining goes 1->0; zero steps finish at once.
                if (cmd_op == OP_READ || cmd_op == OP_LOAD ||
                    remaining <= WIDTH'(1)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered handshake outputs: grant pulse, busy, done pulse and tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            gnt0_q <= take && !pick;
            gnt1_q <= take && pick;
            busy_q <= (state_nxt != IDLE);
            done_q <= finish;
            if (finish) done_id_q <= cmd_id;
        end
    end

    // Command latch at grant, then countdown of remaining steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_op    <= OP_READ;
            remaining <= '0;
            cmd_id    <= 1'b0;
            last_id   <= 1'b1;
        end else if (take) begin
            cmd_op    <= pick ? bus.op1  : bus.op0;
            remaining <= pick ? bus.arg1 : bus.arg0;
            cmd_id    <= pick;
            last_id   <= pick;
        end else if (state == EXEC && cmd_op[1] && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Count register: load or one modular step per EXEC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (state == EXEC) begin
            case (cmd_op)
                OP_LOAD: count_q <= remaining;
                OP_UP:   if (remaining != '0) count_q <= count_q + 1'b1;
                OP_DOWN: if (remaining != '0) count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_updn_cnt_arb.sv
// Self-checking bench for updn_cnt_arb: directed steps then random single commands.
// Latency: checks gnt/done/count cycle by cycle against a transaction-level model.
// Backpressure: exercises ties and requests held while the counter is busy.
module tb_updn_cnt_arb;
    localparam int W = 3;
    localparam int M = 1 << W;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mcount = 0;

    updn_cnt_arb_if #(.WIDTH(W)) bus ();
    updn_cnt_arb #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic r, input logic [1:0] op, input logic [W-1:0] arg);
        if (id == 0) begin
            bus.req0 = r; bus.op0 = op; bus.arg0 = arg;
        end else begin
            bus.req1 = r; bus.op1 = op; bus.arg1 = arg;
        end
    endtask

    // Counter value after applying op with argument k to c.
    function automatic int model(input int c, input logic [1:0] op, input int k);
        case (op)
            OP_LOAD: return k;
            OP_UP:   return (c + k) % M;
            OP_DOWN: return (((c - k) % M) + M) % M;
            default: return c;
        endcase
    endfunction

    // One command from an idle counter, checked every cycle until back in IDLE.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [W-1:0] arg);
        int   waited = 0;
        int   lat;
        int   kk;
        int   start = mcount;
        logic got = 1'b0;
        set_req(id, 1'b1, op, arg);
        while (!got && waited < 20) begin
            tick();
            waited++;
            got = (id == 0) ? bus.gnt0 : bus.gnt1;
        end
        check("gnt_latency", waited, 1);
        check("gnt_other", (id == 0) ? bus.gnt1 : bus.gnt0, 0);
        check("busy_at_gnt", bus.busy, 1);
        set_req(id, 1'b0, op, arg);
        lat = (op[1] && arg != 0) ? int'(arg) : 1;
        for (int i = 1; i <= lat; i++) begin
            tick();
            kk = op[1] ? ((arg == 0) ? 0 : i) : int'(arg);
            check("count_step", bus.count, model(start, op, kk));
            check("done_pulse", bus.done, (i == lat) ? 1 : 0);
        end
        check("done_id", bus.done_id, id);
        mcount = model(start, op, int'(arg));
        tick();
        check("busy_idle", bus.busy, 0);
        check("done_clear", bus.done, 0);
        check("count_final", bus.count, mcount);
    endtask

    // Both clients request UP 1 together; winner then loser.
    task automatic tie_round(input int first);
        int second = 1 - first;
        set_req(0, 1'b1, OP_UP, 3'd1);
        set_req(1, 1'b1, OP_UP, 3'd1);
        tick();
        check("tie_gnt_first", (first == 0) ? bus.gnt0 : bus.gnt1, 1);
        check("tie_gnt_second_low", (first == 0) ? bus.gnt1 : bus.gnt0, 0);
        set_req(first, 1'b0, OP_UP, 3'd1);
        tick();
        check("tie_done1", bus.done, 1);
        check("tie_done_id1", bus.done_id, first);
        check("tie_count1", bus.count, (mcount + 1) % M);
        tick();
        check("tie_idle_gap", bus.busy, 0);
        check("tie_no_early_gnt", (second == 0) ? bus.gnt0 : bus.gnt1, 0);
        tick();
        check("tie_gnt_second", (second == 0) ? bus.gnt0 : bus.gnt1, 1);
        set_req(second, 1'b0, OP_UP, 3'd1);
        tick();
        check("tie_done2", bus.done, 1);
        check("tie_done_id2", bus.done_id, second);
        check("tie_count2", bus.count, (mcount + 2) % M);
        mcount = (mcount + 2) % M;
        tick();
        check("tie_idle_end", bus.busy, 0);
    endtask

    initial begin
        int done_at = -1;
        int gnt_at = -1;
        int rid;
        logic [1:0] rop;
        logic [W-1:0] rarg;
        set_req(0, 1'b0, OP_READ, '0);
        set_req(1, 1'b0, OP_READ, '0);

        // Reset state.
        repeat (3) tick();
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_id", bus.done_id, 0);
        @(negedge clk) reset_n = 1'b1;

        // Reset in the middle of an UP 3.
        set_req(0, 1'b1, OP_UP, 3'd3);
        tick();
        check("mid_gnt0", bus.gnt0, 1);
        set_req(0, 1'b0, OP_UP, 3'd3);
        tick();
        check("mid_step1", bus.count, 1);
        tick();
        check("mid_step2", bus.count, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        repeat (3) begin
            tick();
            check("mid_no_done", bus.done, 0);
        end
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("mid_after_count", bus.count, 0);
        check("mid_after_done", bus.done, 0);
        mcount = 0;

        // Load, step up through wrap, step down through wrap, zero-length commands.
        do_cmd(0, OP_LOAD, 3'd5);
        do_cmd(0, OP_UP, 3'd4);
        do_cmd(1, OP_DOWN, 3'd3);
        do_cmd(1, OP_READ, 3'd0);
        do_cmd(0, OP_UP, 3'd0);

        // Ties after a fresh reset: client 0 first both rounds.
        #2 reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        mcount = 0;
        tie_round(0);
        tie_round(0);

        // Client 1 requests while client 0 runs UP 5.
        set_req(0, 1'b1, OP_UP, 3'd5);
        tick();
        check("busy_gnt0", bus.gnt0, 1);
        set_req(0, 1'b0, OP_UP, 3'd5);
        set_req(1, 1'b1, OP_LOAD, 3'd3);
        for (int c = 1; c <= 20 && gnt_at < 0; c++) begin
            tick();
            if (bus.done && done_at < 0) begin
                done_at = c;
                check("busy_up_count", bus.count, (mcount + 5) % M);
            end
            if (bus.gnt1) begin
                gnt_at = c;
                set_req(1, 1'b0, OP_LOAD, 3'd3);
            end
        end
        check("busy_done_cycle", done_at, 5);
        check("busy_gnt1_cycle", gnt_at, 7);
        tick();
        check("busy_load_done", bus.done, 1);
        check("busy_load_id", bus.done_id, 1);
        check("busy_load_count", bus.count, 3);
        mcount = 3;
        tick();
        check("busy_end_idle", bus.busy, 0);

        // Random single commands against the model.
        repeat (40) begin
            rid  = int'($urandom_range(0, 1));
            rop  = 2'($urandom_range(0, 3));
            rarg = W'($urandom_range(0, M - 1));
            do_cmd(rid, rop, rarg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
